// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with byte enables plus a small MMIO window.
// Reads return one cycle after the request; rdata holds otherwise.
module data_sram_responder #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] MMIO_BASE = 32'h1faf_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SW    = 16'hf020;
  localparam logic [15:0] OFF_TIMER = 16'he000;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       timer;
  logic [31:0]       mmio_rdata;
  logic [31:0]       num_merged;
  logic [31:0]       timer_merged;
  logic [15:0]       led_merged;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic              is_mmio;
  logic              rd;
  logic              wr;

  assign offset  = data_sram_addr[15:0];
  assign idx     = data_sram_addr[ADDR_W+1:2];
  assign is_mmio = data_sram_addr[31:16] == MMIO_BASE[31:16];
  assign rd      = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr      = data_sram_en && (data_sram_wen != 4'b0000);

  always_comb begin
    num_merged   = num_out;
    timer_merged = timer;
    led_merged   = led_out;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) begin
        num_merged[8*i +: 8]   = data_sram_wdata[8*i +: 8];
        timer_merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (data_sram_wen[i]) led_merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      OFF_LED:   mmio_rdata = {16'h0, led_out};
      OFF_NUM:   mmio_rdata = num_out;
      OFF_SW:    mmio_rdata = {16'h0, switch_in};
      OFF_TIMER: mmio_rdata = timer;
      default:   mmio_rdata = 32'h0;
    endcase
  end

  // RAM contents are not reset
  always_ff @(posedge clk) begin
    if (wr && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= 32'h0;
    end else if (rd) begin
      data_sram_rdata <= is_mmio ? mmio_rdata : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= 16'h0;
      num_out <= 32'h0;
    end else if (wr && is_mmio) begin
      if (offset == OFF_LED) led_out <= led_merged;
      if (offset == OFF_NUM) num_out <= num_merged;
    end
  end

  // A timer write replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= 32'h0;
    end else if (wr && is_mmio && offset == OFF_TIMER) begin
      timer <= timer_merged;
    end else begin
      timer <= timer + 32'h1;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table, reset corner case,
// then random traffic checked against a cycle-count based reference model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] num;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk            (clk),
    .rst            (rst),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .switch_in      (sw),
    .led_out        (led),
    .num_out        (num)
  );

  // reference model: timer = value last set + cycles elapsed since then
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rdata;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] t_base;
  int unsigned t_cyc;
  int unsigned cyc = 0;

  function automatic logic [31:0] m_timer();
    return t_base + 32'(cyc - t_cyc);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [15:0] s);
    logic        mm;
    logic [15:0] off;
    int unsigned wi;
    rst = r; en = e; wen = we; addr = a; wdata = d; sw = s;
    @(posedge clk);
    mm  = a[31:16] == 16'h1faf;
    off = a[15:0];
    wi  = int'(a[17:2]);
    if (e && we != 0 && !mm) begin
      if (m_mem.exists(wi)) m_mem[wi] = bmerge(m_mem[wi], d, we);
      else m_mem[wi] = bmerge(32'h0, d, we);
    end
    if (r) begin
      m_rdata = 0; m_led = 0; m_num = 0; t_base = 0; t_cyc = cyc + 1;
    end else if (e && we == 0) begin
      if (!mm) m_rdata = m_mem.exists(wi) ? m_mem[wi] : 32'hx;
      else if (off == 16'hf000) m_rdata = {16'h0, m_led};
      else if (off == 16'hf010) m_rdata = m_num;
      else if (off == 16'hf020) m_rdata = {16'h0, s};
      else if (off == 16'he000) m_rdata = m_timer();
      else m_rdata = 0;
    end else if (e && mm) begin
      if (off == 16'hf000) m_led = 16'(bmerge({16'h0, m_led}, d, we));
      if (off == 16'hf010) m_num = bmerge(m_num, d, we);
      if (off == 16'he000) begin
        t_base = bmerge(m_timer(), d, we);
        t_cyc  = cyc + 1;
      end
    end
    cyc++;
    #1;
    if (!r || cyc > 1) begin
      check("model_rdata", rdata, m_rdata);
      check("model_led", {16'h0, led}, {16'h0, m_led});
      check("model_num", num, m_num);
    end
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic [31:0] e_rdata;
    logic [15:0] e_led;
    logic [31:0] e_num;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic [3:0] we, logic [31:0] a,
                              logic [31:0] d, logic [15:0] s,
                              logic [31:0] er, logic [15:0] el,
                              logic [31:0] en_v);
    vec_t v;
    v.en = e; v.wen = we; v.addr = a; v.wdata = d; v.sw = s;
    v.e_rdata = er; v.e_led = el; v.e_num = en_v;
    return v;
  endfunction

  initial begin
    // vector i runs in the cycle where the timer equals i
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 16'h0, 32'h0));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_e000, 0, 0, 32'd5, 16'h0, 32'h0));
    tbl.push_back(mk(1, 4'hf, 32'h0000_0010, 32'hdeadbeef, 0,
                     32'd5, 16'h0, 32'h0));
    tbl.push_back(mk(1, 4'h2, 32'h0000_0010, 32'h0000_5500, 0,
                     32'd5, 16'h0, 32'h0));
    tbl.push_back(mk(1, 4'h0, 32'h0000_0010, 0, 0, 32'hdead55ef, 0, 0));
    tbl.push_back(mk(1, 4'h0, 32'h0004_0010, 0, 0, 32'hdead55ef, 0, 0));
    tbl.push_back(mk(1, 4'hf, 32'h1faf_f000, 32'h1234, 0,
                     32'hdead55ef, 16'h1234, 0));
    tbl.push_back(mk(1, 4'hf, 32'h1faf_f020, 32'hffff_0000, 0,
                     32'hdead55ef, 16'h1234, 0));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_f020, 0, 16'ha5a5,
                     32'h0000_a5a5, 16'h1234, 0));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_0100, 0, 0, 32'h0, 16'h1234, 0));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_f000, 0, 0, 32'h1234, 16'h1234, 0));
    tbl.push_back(mk(1, 4'hf, 32'h1faf_f010, 32'hcafef00d, 0,
                     32'h1234, 16'h1234, 32'hcafef00d));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_f010, 0, 0,
                     32'hcafef00d, 16'h1234, 32'hcafef00d));
    tbl.push_back(mk(1, 4'hf, 32'h1faf_e000, 32'hffff_fffe, 0,
                     32'hcafef00d, 16'h1234, 32'hcafef00d));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_e000, 0, 0,
                     32'hffff_fffe, 16'h1234, 32'hcafef00d));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_e000, 0, 0,
                     32'hffff_ffff, 16'h1234, 32'hcafef00d));
    tbl.push_back(mk(1, 4'h0, 32'h1faf_e000, 0, 0,
                     32'h0000_0000, 16'h1234, 32'hcafef00d));

    step(1, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(0, tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].sw);
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].e_led});
      check($sformatf("vec%0d_num", i), num, tbl[i].e_num);
    end

    // read, then reset arrives with a NUM write pending
    step(0, 1, 4'h0, 32'h0000_0010, 0, 0);
    check("pre_rst_rdata", rdata, 32'hdead55ef);
    step(1, 1, 4'hf, 32'h1faf_f010, 32'h1111_2222, 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_num", num, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    step(0, 1, 4'h0, 32'h1faf_e000, 0, 0);
    check("rst_timer", rdata, 32'h0);
    step(0, 1, 4'h0, 32'h0000_0010, 0, 0);
    check("ram_kept", rdata, 32'hdead55ef);
    step(0, 1, 4'h6, 32'h0000_0010, 32'h1122_3344, 0);
    step(0, 1, 4'h0, 32'h0000_0013, 0, 0);
    check("lanes_0110", rdata, 32'hde2233ef);

    // random traffic against the model
    for (int i = 0; i < 8; i++)
      step(0, 1, 4'hf, 32'(i * 4), $urandom, 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  we;
      logic [15:0] offs [6];
      offs = '{16'hf000, 16'hf010, 16'hf020, 16'he000, 16'h0100, 16'hf004};
      if ($urandom_range(0, 1) == 0)
        a = (32'($urandom_range(0, 3)) << 18) |
            (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      else
        a = {16'h1faf, offs[$urandom_range(0, 5)]};
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(0, $urandom_range(0, 3) != 0, we, a, $urandom, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface: services en/wen/addr/wdata requests from the CPU top and returns rdata one cycle later.
- Backs a word-organised RAM with per-byte write enables.
- Also decodes a small MMIO window: LED register, number-display register, switch input and a free-running timer.
- Sits in the SoC wrapper beside the CPU top; a copy with wen tied low also serves as the instruction port model.

Parameters:
- ADDR_W, 16, word-address bits of RAM (2^ADDR_W words).
- MMIO_BASE, 32'h1faf_0000, MMIO window base; only bits [31:16] are compared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- data_sram_en  in  1  access request this cycle
- data_sram_wen  in  4  byte write enables; 4'b0000 with en=1 is a read
- data_sram_addr  in  32  byte address (physical, already translated by CPU)
- data_sram_wdata  in  32  write data, byte lanes aligned to wen
- data_sram_rdata  out  32  read data, valid the cycle after the read request
- switch_in  in  16  board switch levels
- led_out  out  16  LED register
- num_out  out  32  number-display register

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-high. rdata=0, led_out=0, num_out=0, timer=0. RAM contents are not reset.
- Decode: MMIO when addr[31:16]==MMIO_BASE[31:16], otherwise RAM.
  - RAM word index = addr[ADDR_W+1:2]; addr[1:0] ignored; higher bits alias.
- One access per cycle; no backpressure; no stall output.
- Write (en=1, wen!=0), effective at the next edge:
  - RAM word: each byte lane i is updated iff wen[i].
  - MMIO registers: same per-byte merge into the current value.
- Read (en=1, wen=0): rdata at cycle T+1 = content at cycle T, with the source select captured at T.
- rdata holds its previous value on idle cycles (en=0) and on write cycles.
- MMIO map (offset = addr[15:0]):
  - 0xF000 LED: RW; bits[15:0] used; upper read as 0.
  - 0xF010 NUM: RW, 32 bits.
  - 0xF020 SWITCH: RO; reads {16'b0, switch_in sampled at T}; writes ignored.
  - 0xE000 TIMER: RW; increments by 1 every cycle and wraps 0xFFFF_FFFF->0.
  - All other offsets: read 0, writes ignored.
- Timer rules:
  - Read at T returns the timer value at T.
  - Write at T: timer(T+1) = merged written value, with no increment that cycle; counting resumes from it.
- Read-after-write: write to X at T, read X at T+1 -> rdata at T+2 is the new value.
- Back-to-back reads: one result per cycle, pipelined, in order.
- Reset mid-operation: a read issued in the reset cycle returns nothing (rdata=0 next cycle); a write coinciding with rst is discarded for MMIO registers and timer.
- Unaligned byte enables (e.g. 4'b0110) are legal; lanes are applied independently.

Test Plan:
- Reset then idle 5 cycles -> rdata=0, led_out=0, num_out=0; read 0x1faf_e000 at cycle 5 after reset -> rdata=5 (±0 per defined sampling).
- Write 0xDEADBEEF wen=1111 to 0x0000_0010, then wen=0010 data 0x0000_5500 same address, read -> rdata=0xDEAD55EF exactly one cycle after the read request.
- Read 0x0000_0010 and 0x0004_0010 with ADDR_W=16 -> both return the same word (aliasing).
- Write 0x1234 to 0x1faf_f000 -> led_out=0x1234 next cycle. Write 0xFFFF_0000 to 0x1faf_f020 -> no effect. switch_in=0xA5A5, read 0x1faf_f020 -> rdata=0x0000A5A5. Read 0x1faf_0100 -> 0.
- Write timer 0xFFFF_FFFE at T -> reads at T+1, T+2, T+3 return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- Issue a read, assert rst the following cycle while a write to NUM is pending -> rdata=0 and num_out=0 after reset; RAM word written before reset is still readable.
